// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared types and defaults for the fifo_reader drain controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_t;

    localparam int DW_DEFAULT    = 8;
    localparam int CNT_W_DEFAULT = 16;

    // The state encoding doubles as the number of buffered words.
    function automatic logic [1:0] occ_words(input buf_state_t s);
        return 2'(s);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// ============================================================================
// fifo_skid_buf : 2-entry head/tail skid buffer with occupancy FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          capture,
    input  logic [DW-1:0] wdata,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic          valid,
    output buf_state_t    occ
);

    buf_state_t    state;
    buf_state_t    state_nxt;
    logic [DW-1:0] head;
    logic [DW-1:0] head_nxt;
    logic [DW-1:0] tail;
    logic [DW-1:0] tail_nxt;
    logic          pop;

    assign valid = (state != B0);
    assign pop   = valid & ready;
    assign data  = head;
    assign occ   = state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= B0;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            B0: begin
                if (capture) begin
                    head_nxt  = wdata;
                    state_nxt = B1;
                end
            end
            B1: begin
                case ({capture, pop})
                    2'b10: begin
                        tail_nxt  = wdata;
                        state_nxt = B2;
                    end
                    2'b01:   state_nxt = B0;
                    2'b11:   head_nxt  = wdata;
                    default: state_nxt = B1;
                endcase
            end
            B2: begin
                // Credit logic keeps capture out of B2 unless a pop frees the head.
                if (pop) begin
                    head_nxt = tail;
                    if (capture) begin
                        tail_nxt = wdata;
                    end else begin
                        state_nxt = B1;
                    end
                end
            end
            default: state_nxt = B0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fifo_reader.sv
// ============================================================================
// fifo_reader : FIFO read-side drain controller with valid/ready output stream
// Revision : 1.0   (optional popped-word counter: FIFO_READER_CNT_EN)
// ============================================================================
`default_nettype none

module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             empty,
    input  logic [DW-1:0]    fifo_rdata,
    output logic             ren,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_W-1:0] rd_count
`endif
);

    logic       inflight;
    logic       active;
    logic       pop;
    logic [2:0] credit_used;
    buf_state_t occ;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("fifo_reader: CNT_W must be at least 1");
    end

    assign pop = m_valid & m_ready;

    // A word leaving the head this cycle frees its slot before the new pop lands,
    // which is what allows one word per clock with m_ready held high.
    assign credit_used = 3'(occ_words(occ)) + 3'(inflight) - 3'(pop);
    assign ren         = active & ~empty & (credit_used < 3'd2);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inflight <= 1'b0;
            active   <= 1'b0;
        end else begin
            inflight <= ren;
            active   <= 1'b1;
        end
    end

    fifo_skid_buf #(
        .DW (DW)
    ) u_buf (
        .clk     (clk),
        .nrst    (nrst),
        .capture (inflight),
        .wdata   (fifo_rdata),
        .ready   (m_ready),
        .data    (m_data),
        .valid   (m_valid),
        .occ     (occ)
    );

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire
